// File: rtl/eth_frame_gen.sv
// eth_frame_gen: builds Ethernet frames (dst MAC, src MAC, EtherType, counting
// payload) and streams them as 32-bit Avalon-ST words with sop/eop/empty.
//
// Handshake: a word transfers on a rising edge where out_valid && out_ready.
// While out_valid is high and out_ready is low, out_data/out_sop/out_eop/
// out_empty are held. out_valid never drops between the sop and eop words.
module eth_frame_gen #(
  parameter int IFG_CYCLES  = 12,
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ethertype,
  input  logic [10:0] payload_len,
  input  logic [7:0]  seed,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic [1:0]  out_empty,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam logic [10:0] MIN_P    = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_P    = 11'(MAX_PAYLOAD);
  localparam logic [15:0] GAP_LOAD = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

  state_t       state, state_next;
  logic [111:0] hdr_q;        // {dst, src, ethertype}, byte 0 in the top bits
  logic [7:0]   seed_q;
  logic [10:0]  len_q;        // frame length in bytes
  logic [10:0]  last_w_q;     // index of the eop word
  logic [10:0]  w_q;          // index of the word currently presented
  logic [1:0]   empty_q;
  logic [15:0]  gap_q;

  logic [10:0]  pay_clamp;
  logic [10:0]  frame_len;
  logic [10:0]  frame_words;
  logic         accept;
  logic         xfer;
  logic         last_word;
  logic [10:0]  b;
  logic [6:0]   hi;
  logic [7:0]   byte_val;

  assign accept    = (state == IDLE) && start;
  assign xfer      = out_valid && out_ready;
  assign last_word = (w_q == last_w_q);

  // Clamp the requested payload and derive frame length and word count.
  always_comb begin
    pay_clamp = payload_len;
    if (payload_len < MIN_P)      pay_clamp = MIN_P;
    else if (payload_len > MAX_P) pay_clamp = MAX_P;
    frame_len   = pay_clamp + 11'd14;
    frame_words = (frame_len + 11'd3) >> 2;
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: start only matters in IDLE; the gap follows the eop transfer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = SEND;
      SEND: if (xfer && last_word) state_next = (IFG_CYCLES == 0) ? IDLE : GAP;
      GAP:  if (gap_q == 16'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch frame fields on start, advance the word index on transfers, run the gap timer.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      hdr_q       <= '0;
      seed_q      <= '0;
      len_q       <= '0;
      last_w_q    <= '0;
      w_q         <= '0;
      empty_q     <= '0;
      gap_q       <= '0;
      frames_sent <= '0;
    end else begin
      if (accept) begin
        hdr_q    <= {dst_mac, src_mac, ethertype};
        seed_q   <= seed;
        len_q    <= frame_len;
        last_w_q <= frame_words - 11'd1;
        empty_q  <= 2'd0 - frame_len[1:0];
        w_q      <= '0;
      end else if (xfer && !last_word) begin
        w_q <= w_q + 11'd1;
      end
      if (xfer && last_word) begin
        frames_sent <= frames_sent + 16'd1;
        gap_q       <= GAP_LOAD;
      end else if (state == GAP && gap_q != 16'd0) begin
        gap_q <= gap_q - 16'd1;
      end
    end
  end

  // Assemble the presented word: header bytes, then seed-based payload, zero past the end.
  always_comb begin
    out_data = 32'd0;
    b        = '0;
    hi       = '0;
    byte_val = '0;
    for (int i = 0; i < 4; i++) begin
      b  = (w_q << 2) + 11'(i);
      hi = 7'd104 - {b[3:0], 3'b000};
      if (b < 11'd14)      byte_val = hdr_q[hi +: 8];
      else if (b < len_q)  byte_val = seed_q + b[7:0] - 8'd14;
      else                 byte_val = 8'd0;
      if (state == SEND) out_data[31 - 8*i -: 8] = byte_val;
    end
  end

  assign out_valid = (state == SEND);
  assign out_sop   = (state == SEND) && (w_q == 11'd0);
  assign out_eop   = (state == SEND) && last_word;
  assign out_empty = out_eop ? empty_q : 2'd0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_eth_frame_gen.sv
// Testbench for eth_frame_gen: a reference model expands each frame into its
// expected words, a monitor pops and compares them on every transfer.
module tb_eth_frame_gen;

  localparam int IFG = 12;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [47:0] dst_mac = '0;
  logic [47:0] src_mac = '0;
  logic [15:0] ethertype = '0;
  logic [10:0] payload_len = '0;
  logic [7:0]  seed = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sop;
  logic        out_eop;
  logic [1:0]  out_empty;
  logic        busy;
  logic [15:0] frames_sent;

  int checks = 0;
  int failures = 0;
  int exp_frames = 0;
  int ready_mode = 0;
  logic [35:0] exp_q[$];

  // clock / reset block
  always #5 sys_clk = ~sys_clk;

  eth_frame_gen dut (
    .sys_clk(sys_clk), .reset(reset), .start(start), .dst_mac(dst_mac),
    .src_mac(src_mac), .ethertype(ethertype), .payload_len(payload_len),
    .seed(seed), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .out_empty(out_empty), .busy(busy), .frames_sent(frames_sent)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference model: list the frame bytes, then cut them into words.
  task automatic push_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                            input int plen, input logic [7:0] sd);
    logic [7:0]  fb[0:1519];
    logic [31:0] data;
    int p, l, n, idx, emp;
    p = (plen < 46) ? 46 : ((plen > 1500) ? 1500 : plen);
    l = 14 + p;
    n = (l + 3) / 4;
    for (int k = 0; k < l; k++) begin
      if (k < 6)       fb[k] = d[8*(5-k) +: 8];
      else if (k < 12) fb[k] = s[8*(11-k) +: 8];
      else if (k < 14) fb[k] = t[8*(13-k) +: 8];
      else             fb[k] = 8'((int'(sd) + k - 14) % 256);
    end
    for (int w = 0; w < n; w++) begin
      data = '0;
      for (int i = 0; i < 4; i++) begin
        idx  = 4*w + i;
        data = {data[23:0], (idx < l) ? fb[idx] : 8'h00};
      end
      emp = (w == n-1) ? (4 - l % 4) % 4 : 0;
      exp_q.push_back({data, (w == 0), (w == n-1), 2'(emp)});
    end
  endtask

  // Sink ready: always high or a fair coin per cycle.
  always @(posedge sys_clk) begin
    #1;
    out_ready = (ready_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Monitor / scoreboard.
  logic        stall_prev = 1'b0;
  logic [35:0] stall_val = '0;
  logic        in_frame = 1'b0;
  logic        gap_on = 1'b0;
  int          gap_cnt = 0;
  always @(negedge sys_clk) begin
    logic [35:0] cur, exp_w;
    cur = {out_data, out_sop, out_eop, out_empty};
    if (reset) begin
      exp_q.delete();
      exp_frames = 0;
      stall_prev = 1'b0;
      in_frame   = 1'b0;
      gap_on     = 1'b0;
    end else begin
      check("frames_sent", 64'(frames_sent), 64'(exp_frames % 65536));
      if (stall_prev) check("stall_hold", {out_valid, cur}, {1'b1, stall_val});
      if (in_frame) check("no_bubble", 64'(out_valid), 64'd1);
      if (gap_on) begin
        if (busy) gap_cnt++;
        else begin
          check("ifg_len", 64'(gap_cnt), 64'(IFG));
          gap_on = 1'b0;
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=0x%0h required=none", cur);
        end else begin
          exp_w = exp_q.pop_front();
          check("word", cur, exp_w);
        end
        if (out_sop) in_frame = 1'b1;
        if (out_eop) begin
          in_frame = 1'b0;
          exp_frames++;
          gap_on  = 1'b1;
          gap_cnt = 0;
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_val  = cur;
    end
  end

  // Driver: wait for idle, pulse start with the fields, check sop the next cycle.
  task automatic send_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                            input int plen, input logic [7:0] sd);
    int guard;
    guard = 0;
    @(posedge sys_clk); #1;
    while (busy && guard < 5000) begin
      @(posedge sys_clk); #1;
      guard++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
    dst_mac = d; src_mac = s; ethertype = t; payload_len = 11'(plen); seed = sd;
    start = 1'b1;
    push_frame(d, s, t, plen, sd);
    @(posedge sys_clk); #1;
    start = 1'b0;
    @(negedge sys_clk);
    check("sop_latency", {out_valid, out_sop}, 2'b11);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    @(negedge sys_clk);
    while ((exp_q.size() != 0 || busy) && guard < 5000) begin
      @(negedge sys_clk);
      guard++;
    end
    if (exp_q.size() != 0 || busy) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=pending%0d required=pending0", exp_q.size());
    end
  endtask

  task automatic pulse_start_junk();
    dst_mac = 48'hDEADBEEF0001; src_mac = 48'hDEADBEEF0002; ethertype = 16'h86DD;
    payload_len = 11'd300; seed = 8'h5A;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  initial begin
    logic [47:0] rd, rs;
    logic [15:0] rt;
    int guard;

    repeat (3) @(posedge sys_clk);
    #1 reset = 1'b0;
    @(negedge sys_clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_sop_eop_empty", {out_sop, out_eop, out_empty}, 4'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frames", 64'(frames_sent), 64'd0);

    // Directed lengths with the sink always ready.
    ready_mode = 0;
    send_frame(48'h001122334455, 48'h66778899AABB, 16'h0800, 46, 8'h00);
    wait_done();
    check("frames_after_first", 64'(frames_sent), 64'd1);
    send_frame(48'h001122334455, 48'h66778899AABB, 16'h0800, 47, 8'h00);
    wait_done();
    send_frame(48'h0A0B0C0D0E0F, 48'h101112131415, 16'h88B5, 10, 8'h33);
    wait_done();
    send_frame(48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0806, 2000, 8'h80);
    wait_done();
    send_frame(48'h123456789ABC, 48'hCBA987654321, 16'h0800, 0, 8'hC0);
    wait_done();

    // 64-byte frame under random backpressure.
    ready_mode = 1;
    send_frame(48'h001122334455, 48'h66778899AABB, 16'h0800, 50, 8'h10);
    wait_done();

    // Randomized frames, mixed backpressure.
    for (int f = 0; f < 10; f++) begin
      ready_mode = $urandom_range(0, 1);
      rd = {16'($urandom()), 32'($urandom())};
      rs = {16'($urandom()), 32'($urandom())};
      rt = 16'($urandom());
      send_frame(rd, rs, rt,
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 60) : $urandom_range(0, 2047),
                 8'($urandom()));
      wait_done();
    end

    // start during SEND and during GAP must be ignored.
    ready_mode = 0;
    send_frame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h0800, 200, 8'h01);
    repeat (10) @(posedge sys_clk);
    #1 pulse_start_junk();
    guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(negedge sys_clk);
      guard++;
    end
    @(posedge sys_clk); #1;
    check("in_gap", 64'(busy && !out_valid), 64'd1);
    pulse_start_junk();
    wait_done();
    repeat (30) @(negedge sys_clk);
    check("ignored_idle", {out_valid, busy}, 2'b00);
    check("ignored_frames", 64'(frames_sent), 64'(exp_frames % 65536));

    // Seed wrap.
    send_frame(48'h001122334455, 48'h66778899AABB, 16'h0800, 46, 8'hFF);
    wait_done();

    // Reset while word 5 is presented, then a clean frame.
    send_frame(48'h001122334455, 48'h66778899AABB, 16'h0800, 100, 8'h20);
    repeat (5) @(posedge sys_clk);
    #1 reset = 1'b1;
    @(posedge sys_clk);
    #1 reset = 1'b0;
    @(negedge sys_clk);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_frames", 64'(frames_sent), 64'd0);
    send_frame(48'h001122334455, 48'h66778899AABB, 16'h0800, 64, 8'h7E);
    wait_done();
    check("post_rst_frames", 64'(frames_sent), 64'd1);

    repeat (20) @(negedge sys_clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
